// File: rtl/xfer_pkg.sv
// Shared types and helpers for the level-handshake crossing scheduler.
package xfer_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PH_HI,
      PH_LO,
      FIN,
      ABORT
   } state_t;

   localparam int unsigned N_REQ_DEF   = 4;
   localparam int unsigned DW_DEF      = 8;
   localparam int unsigned TIMEOUT_DEF = 255;

   // Ceiling log2, never below 1 so a 1-bit field always exists.
   function automatic int unsigned clog2(input int unsigned x);
      int unsigned w;
      w = 1;
      while ((64'd1 << w) < 64'(x)) w++;
      return w;
   endfunction

   // Wait counter must hold values 0..timeout.
   function automatic int unsigned to_cnt_w(input int unsigned timeout);
      return clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter
   import xfer_pkg::*;
#(
   parameter  int unsigned N  = 4,
   localparam int unsigned IW = clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] gnt_idx_o
);

   logic [IW-1:0] idx;
   logic          found;

   // Scan N positions starting at ptr; the first hit wins
   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      found     = 1'b0;
      idx       = '0;
      for (int unsigned i = 0; i < N; i++) begin
         idx = IW'((32'(ptr_i) + i) % N);
         if (!found && req_i[idx]) begin
            found      = 1'b1;
            gnt_o[idx] = 1'b1;
            gnt_idx_o  = idx;
         end
      end
   end

endmodule

// File: rtl/level_xfer_sched.sv
// Round-robin scheduler sharing one 4-phase level-handshake crossing
// between N_REQ source-domain requesters.
module level_xfer_sched
   import xfer_pkg::*;
#(
   parameter  int unsigned N_REQ   = N_REQ_DEF,
   parameter  int unsigned DW      = DW_DEF,
   parameter  int unsigned TIMEOUT = TIMEOUT_DEF,
   localparam int unsigned IW      = clog2(N_REQ)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_REQ-1:0]    req,
   input  logic [N_REQ*DW-1:0] req_data,
   output logic [N_REQ-1:0]    done,
   output logic                busy,
   output logic                xfer_lvl,
   output logic [DW-1:0]       xfer_data,
   output logic [IW-1:0]       xfer_id,
   input  logic                ack_lvl,
   output logic                timeout_err
);

   localparam int unsigned CNT_W = to_cnt_w(TIMEOUT);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IW-1:0]    ptr_q, ptr_d;
   logic [IW-1:0]    id_q;
   logic [N_REQ-1:0] mask_q;
   logic [DW-1:0]    data_q;
   logic             lvl_q, lvl_d;
   logic             to_q, to_d;
   logic [N_REQ-1:0] gnt;
   logic [IW-1:0]    gnt_idx;
   logic             wait_expired;

   rr_arbiter #(.N(N_REQ)) u_arb (
      .req_i     (req),
      .ptr_i     (ptr_q),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx)
   );

   assign wait_expired = (cnt_q == CNT_W'(TIMEOUT - 1));

   // State, wait counter, pointer and the flopped handshake/error outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ptr_q   <= '0;
         lvl_q   <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         lvl_q   <= lvl_d;
         to_q    <= to_d;
      end
   end

   // Next state; the counter only advances while staying in a wait phase,
   // so any state change clears it
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            if ((|req) && !ack_lvl) state_d = PH_HI;
         end
         PH_HI: begin
            if (ack_lvl)           state_d = PH_LO;
            else if (wait_expired) state_d = ABORT;
            else                   cnt_d   = cnt_q + 1'b1;
         end
         PH_LO: begin
            if (!ack_lvl)          state_d = FIN;
            else if (wait_expired) state_d = ABORT;
            else                   cnt_d   = cnt_q + 1'b1;
         end
         FIN: begin
            state_d = IDLE;
         end
         ABORT: begin
            if (!ack_lvl) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if ((state_q == FIN) || (state_q == ABORT))
         ptr_d = (id_q == IW'(N_REQ - 1)) ? '0 : id_q + 1'b1;
   end

   // Outputs; xfer_lvl and timeout_err come straight from flops since
   // xfer_lvl feeds a synchronizer and must not glitch on state decode
   always_comb begin
      lvl_d = (state_d == PH_HI);
      to_d  = (state_d == ABORT) && (state_q != ABORT);
      done  = (state_q == FIN) ? mask_q : '0;
      busy  = (state_q != IDLE);
   end

   // Payload, id and winner mask captured once at grant, held until next grant
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
         id_q   <= '0;
         mask_q <= '0;
      end else if ((state_q == IDLE) && (state_d == PH_HI)) begin
         data_q <= req_data[gnt_idx*DW +: DW];
         id_q   <= gnt_idx;
         mask_q <= gnt;
      end
   end

   assign xfer_lvl    = lvl_q;
   assign timeout_err = to_q;
   assign xfer_data   = data_q;
   assign xfer_id     = id_q;

endmodule

// File: tb/tb_level_xfer_sched.sv
// Self-checking bench for level_xfer_sched with a behavioural arbitration model
// and a far-side model that echoes xfer_lvl back as ack_lvl after a delay.
module tb_level_xfer_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  done;
   logic        busy;
   logic        xfer_lvl;
   logic [7:0]  xfer_data;
   logic [1:0]  xfer_id;
   logic        ack_lvl;
   logic        timeout_err;

   int checks = 0;
   int errors = 0;
   int m_ptr  = 0;
   int to_pulses = 0;
   int done_pulses = 0;

   // Far side: ack follows xfer_lvl after (ack_sel+1) cycles, or is forced
   logic [2:0] sr = '0;
   logic [1:0] ack_sel = 2'd1;
   bit ack_force_en = 1'b1;
   bit ack_force = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) sr <= {sr[1:0], xfer_lvl};
   assign ack_lvl = ack_force_en ? ack_force : sr[ack_sel];

   always @(negedge clk) begin
      if (timeout_err) to_pulses++;
      if (done != 4'b0) done_pulses++;
   end

   level_xfer_sched #(.N_REQ(4), .DW(8), .TIMEOUT(255)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .req_data    (req_data),
      .done        (done),
      .busy        (busy),
      .xfer_lvl    (xfer_lvl),
      .xfer_data   (xfer_data),
      .xfer_id     (xfer_id),
      .ack_lvl     (ack_lvl),
      .timeout_err (timeout_err)
   );

   // Reference rule: first set request at or after p, wrapping
   function automatic int rr_pick(input logic [3:0] r, input int p);
      for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
      return -1;
   endfunction

   function automatic logic [7:0] slice(input logic [31:0] d, input int i);
      return d[i*8 +: 8];
   endfunction

   function automatic int lat();
      return int'(ack_sel) + 1;
   endfunction

   task automatic wait_grant(input int maxc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         @(negedge clk);
         if (xfer_lvl) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_done(input int maxc, output bit ok, output int n, output logic [3:0] d);
      ok = 1'b0; n = 0; d = '0;
      for (int i = 0; i < maxc; i++) begin
         @(negedge clk);
         n++;
         if (done !== 4'b0) begin ok = 1'b1; d = done; break; end
      end
   endtask

   task automatic test_reset();
      bit ok; int n; logic [3:0] d; logic [7:0] expd;
      rst = 1'b1; req = 4'b0001; req_data = $urandom;
      ack_force_en = 1'b0; ack_sel = 2'd1;
      repeat (3) @(negedge clk);
      checks++;
      if ({xfer_lvl, busy, done, timeout_err, xfer_id, xfer_data} !== 16'h0)
         $display("FAIL reset_outputs: got %h expected 0",
                  {xfer_lvl, busy, done, timeout_err, xfer_id, xfer_data});
      if ({xfer_lvl, busy, done, timeout_err, xfer_id, xfer_data} !== 16'h0) errors++;
      expd = slice(req_data, 0);
      rst = 1'b0; m_ptr = 0;
      wait_grant(1, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL reset_first_grant: xfer_lvl=%b expected 1", xfer_lvl); end
      checks++;
      if (xfer_id !== 2'd0 || xfer_data !== expd) begin
         errors++;
         $display("FAIL reset_id_data: got id=%0d data=%h expected id=0 data=%h", xfer_id, xfer_data, expd);
      end
      wait_done(40, ok, n, d);
      checks++;
      if (!ok || d !== 4'b0001 || n != 2*lat()+2) begin
         errors++;
         $display("FAIL reset_done: got done=%b after %0d expected 0001 after %0d", d, n, 2*lat()+2);
      end
      m_ptr = 1; req = 4'b0;
      @(negedge clk);
   endtask

   task automatic test_round_robin();
      bit ok; int n; int e; logic [3:0] d; logic [7:0] expd;
      rst = 1'b1; req = 4'b1111; req_data = $urandom;
      ack_force_en = 1'b0; ack_sel = 2'($urandom_range(0, 2));
      repeat (2) @(negedge clk);
      rst = 1'b0; m_ptr = 0;
      for (int t = 0; t < 5; t++) begin
         e = rr_pick(req, m_ptr); expd = slice(req_data, e);
         wait_grant(4, ok);
         checks++;
         if (!ok || xfer_id !== 2'(e) || xfer_data !== expd) begin
            errors++;
            $display("FAIL rr_grant[%0d]: got id=%0d data=%h expected id=%0d data=%h",
                     t, xfer_id, xfer_data, e, expd);
         end
         wait_done(40, ok, n, d);
         checks++;
         if (!ok || d !== 4'(1 << e) || n != 2*lat()+2) begin
            errors++;
            $display("FAIL rr_done[%0d]: got %b after %0d expected %b after %0d",
                     t, d, n, 4'(1 << e), 2*lat()+2);
         end
         m_ptr = (e + 1) % 4;
         req_data = $urandom;
         if (t == 4) req = 4'b0;
         @(negedge clk);
         checks++;
         if (busy !== 1'b0 || xfer_lvl !== 1'b0) begin
            errors++;
            $display("FAIL rr_idle_gap[%0d]: got busy=%b lvl=%b expected 0 0", t, busy, xfer_lvl);
         end
      end
   endtask

   task automatic test_random();
      bit ok; int n; int e; logic [3:0] d; logic [7:0] expd;
      ack_force_en = 1'b0; ack_sel = 2'($urandom_range(0, 2));
      req = 4'($urandom_range(1, 15)); req_data = $urandom;
      for (int t = 0; t < 10; t++) begin
         e = rr_pick(req, m_ptr); expd = slice(req_data, e);
         wait_grant(4, ok);
         checks++;
         if (!ok || xfer_id !== 2'(e) || xfer_data !== expd) begin
            errors++;
            $display("FAIL rand_grant[%0d]: req=%b got id=%0d data=%h expected id=%0d data=%h",
                     t, req, xfer_id, xfer_data, e, expd);
         end
         wait_done(40, ok, n, d);
         checks++;
         if (!ok || d !== 4'(1 << e) || n != 2*lat()+2) begin
            errors++;
            $display("FAIL rand_done[%0d]: got %b after %0d expected %b after %0d",
                     t, d, n, 4'(1 << e), 2*lat()+2);
         end
         m_ptr = (e + 1) % 4;
         if (t == 9) req = 4'b0;
         else begin req = 4'($urandom_range(1, 15)); req_data = $urandom; end
         @(negedge clk);
         ack_sel = 2'($urandom_range(0, 2));
      end
   endtask

   task automatic test_timeout();
      bit ok; int n; int e; int to_base; int dn_base; logic [3:0] d;
      ack_force_en = 1'b1; ack_force = 1'b0;
      to_base = to_pulses; dn_base = done_pulses;
      req = 4'b0100; e = rr_pick(req, m_ptr);
      wait_grant(4, ok);
      checks++;
      if (!ok || xfer_id !== 2'(e)) begin
         errors++;
         $display("FAIL to_grant: got id=%0d expected %0d", xfer_id, e);
      end
      n = 0;
      do begin @(negedge clk); n++; end while (xfer_lvl && n < 400);
      checks++;
      if (n != 255) begin errors++; $display("FAIL to_cycles: got %0d expected 255", n); end
      checks++;
      if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_pulse: got %b expected 1", timeout_err); end
      req = 4'b0;
      @(negedge clk);
      checks++;
      if (timeout_err !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL to_pulse_end: got err=%b busy=%b expected 0 0", timeout_err, busy);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (to_pulses - to_base != 1 || done_pulses != dn_base) begin
         errors++;
         $display("FAIL to_counts: got pulses=%0d dones=%0d expected 1 0",
                  to_pulses - to_base, done_pulses - dn_base);
      end
      m_ptr = (e + 1) % 4;
      ack_force_en = 1'b0; req = 4'b1111; e = rr_pick(req, m_ptr);
      wait_grant(4, ok);
      checks++;
      if (!ok || xfer_id !== 2'(e) || e != 3) begin
         errors++;
         $display("FAIL to_next_grant: got id=%0d expected 3", xfer_id);
      end
      wait_done(40, ok, n, d);
      checks++;
      if (!ok || d !== 4'b1000) begin errors++; $display("FAIL to_next_done: got %b expected 1000", d); end
      m_ptr = 0; req = 4'b0;
      @(negedge clk);
   endtask

   task automatic test_stale_ack();
      bit ok; int n; int e; logic [3:0] d;
      ack_force_en = 1'b1; ack_force = 1'b1;
      req = 4'b0010;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if (busy !== 1'b0 || xfer_lvl !== 1'b0) begin
            errors++;
            $display("FAIL stale_block[%0d]: got busy=%b lvl=%b expected 0 0", i, busy, xfer_lvl);
         end
      end
      ack_force_en = 1'b0; e = rr_pick(req, m_ptr);
      wait_grant(1, ok);
      checks++;
      if (!ok || xfer_id !== 2'(e)) begin
         errors++;
         $display("FAIL stale_grant: got lvl=%b id=%0d expected 1 %0d", xfer_lvl, xfer_id, e);
      end
      wait_done(40, ok, n, d);
      checks++;
      if (!ok || d !== 4'b0010 || n != 2*lat()+2) begin
         errors++;
         $display("FAIL stale_done: got %b after %0d expected 0010 after %0d", d, n, 2*lat()+2);
      end
      m_ptr = (e + 1) % 4; req = 4'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      bit ok; int n; int e; logic [3:0] d;
      ack_force_en = 1'b0; req = 4'b1000;
      wait_grant(4, ok);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (xfer_lvl !== 1'b0 || busy !== 1'b0 || xfer_id !== 2'd0) begin
         errors++;
         $display("FAIL reset_mid_drop: got lvl=%b busy=%b id=%0d expected 0 0 0", xfer_lvl, busy, xfer_id);
      end
      m_ptr = 0; ack_force_en = 1'b1; ack_force = 1'b1; req = 4'b1111;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (busy !== 1'b0 || xfer_lvl !== 1'b0) begin
            errors++;
            $display("FAIL reset_stale_block[%0d]: got busy=%b lvl=%b expected 0 0", i, busy, xfer_lvl);
         end
      end
      ack_force_en = 1'b0; e = rr_pick(req, m_ptr);
      wait_grant(1, ok);
      checks++;
      if (!ok || xfer_id !== 2'(e)) begin
         errors++;
         $display("FAIL reset_mid_grant: got lvl=%b id=%0d expected 1 %0d", xfer_lvl, xfer_id, e);
      end
      wait_done(40, ok, n, d);
      checks++;
      if (!ok || d !== 4'(1 << e)) begin
         errors++;
         $display("FAIL reset_mid_done: got %b expected %b", d, 4'(1 << e));
      end
      m_ptr = (e + 1) % 4; req = 4'b0;
      @(negedge clk);
   endtask

   task automatic test_withdraw();
      bit ok; int n; int e; logic [3:0] d; logic [7:0] expd;
      ack_force_en = 1'b0; ack_sel = 2'd2;
      req = 4'b1000; req_data = $urandom;
      e = rr_pick(req, m_ptr); expd = slice(req_data, e);
      wait_grant(4, ok);
      checks++;
      if (!ok || xfer_id !== 2'(e) || xfer_data !== expd) begin
         errors++;
         $display("FAIL wd_grant: got id=%0d data=%h expected id=%0d data=%h", xfer_id, xfer_data, e, expd);
      end
      req = 4'b0; req_data = ~req_data;
      ok = 1'b0; d = '0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         checks++;
         if (xfer_data !== expd) begin
            errors++;
            $display("FAIL wd_data_hold[%0d]: got %h expected %h", i, xfer_data, expd);
         end
         if (done !== 4'b0) begin ok = 1'b1; d = done; end
      end
      checks++;
      if (!ok || d !== 4'b1000) begin errors++; $display("FAIL wd_done: got %b expected 1000", d); end
      m_ptr = (e + 1) % 4;
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; req = 4'b0; req_data = '0;
      test_reset();
      test_round_robin();
      test_random();
      test_timeout();
      test_stale_ack();
      test_reset_mid();
      test_withdraw();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
